// File: rtl/rat_pkg.sv
// Shared types and constants for the rational (rat) datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rat_pkg;

  // Default datapath width for num/den terms
  localparam int RAT_WIDTH = 32;

  // Reduction FSM states
  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    TWOS,
    GCD,
    DIV,
    DONE
  } rat_state_e;

  // Worst-case cycles from input transfer to out_valid for a given width
  function automatic int unsigned rat_lat_bound(input int unsigned width);
    return 4 * width + 8;
  endfunction

endpackage

// File: rtl/rat_udiv.sv
// Sequential restoring unsigned divider, one quotient bit per cycle.
// Latency: start sampled, then exactly WIDTH iterations; done pulses one cycle after the last.
// Backpressure: none; a new start restarts the divider, results hold until the next start.
module rat_udiv import rat_pkg::*; #(
  parameter int WIDTH = RAT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;

  logic [WIDTH:0]   shift_d, trial_d;
  logic [WIDTH-1:0] rem_d, quo_d;

  // One restoring step: bring in the next dividend bit, subtract if it fits
  always_comb begin
    shift_d = {rem_q, quo_q[WIDTH-1]};
    trial_d = shift_d - {1'b0, dvs_q};
    rem_d   = shift_d[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial_d[WIDTH]) begin
      rem_d = trial_d[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Operand load on start, then iterate WIDTH times and pulse done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= '0;
        quo_q  <= dividend;
        dvs_q  <= divisor;
        cnt_q  <= CW'(WIDTH);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/rat_reduce.sv
// Reduces unsigned num/den to lowest terms (binary GCD, then divide both by it); RAT_REDUCE_GCD_PORT_EN adds out_gcd.
// Latency: 2 cycles for zero/error pairs, otherwise variable, bounded by 4*WIDTH+8 cycles.
// Backpressure: one pair in flight; in_ready low while busy, result held in DONE until out_ready.
module rat_reduce import rat_pkg::*; #(
  parameter int WIDTH = RAT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_num,
  output logic [WIDTH-1:0] out_den,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
`ifdef RAT_REDUCE_GCD_PORT_EN
  ,output logic [WIDTH-1:0] out_gcd
`endif
);

  localparam int KW = $clog2(WIDTH) + 1;

  rat_state_e       state_q;
  logic [WIDTH-1:0] num_q, den_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] g_q;
  logic             div_start_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_err_q;
  logic [WIDTH-1:0] out_num_q, out_den_q;
`ifdef RAT_REDUCE_GCD_PORT_EN
  logic [WIDTH-1:0] out_gcd_q;
`endif

  logic [WIDTH-1:0] q_num, q_den, r_num, r_den;
  logic             done_num, done_den;

  // Both terms are divided by the same g, so the two dividers finish together
  rat_udiv #(.WIDTH(WIDTH)) u_div_num (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_q),
    .dividend  (num_q),
    .divisor   (g_q),
    .quotient  (q_num),
    .remainder (r_num),
    .done      (done_num)
  );

  rat_udiv #(.WIDTH(WIDTH)) u_div_den (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_q),
    .dividend  (den_q),
    .divisor   (g_q),
    .quotient  (q_den),
    .remainder (r_den),
    .done      (done_den)
  );

  // Reduction FSM: capture, screen zero cases, strip common twos, Stein loop, divide, hold result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      num_q       <= '0;
      den_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      g_q         <= '0;
      div_start_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_num_q   <= '0;
      out_den_q   <= '0;
`ifdef RAT_REDUCE_GCD_PORT_EN
      out_gcd_q   <= '0;
`endif
    end else begin
      div_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            num_q      <= in_num;
            den_q      <= in_den;
            a_q        <= in_num;
            b_q        <= in_den;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (den_q == '0) begin
            out_err_q   <= 1'b1;
            out_num_q   <= num_q;
            out_den_q   <= '0;
`ifdef RAT_REDUCE_GCD_PORT_EN
            out_gcd_q   <= '0;
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (num_q == '0) begin
            out_err_q   <= 1'b0;
            out_num_q   <= '0;
            out_den_q   <= WIDTH'(1);
`ifdef RAT_REDUCE_GCD_PORT_EN
            out_gcd_q   <= den_q;
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= TWOS;
          end
        end
        TWOS: begin
          // Common factors of two are counted in k and restored after the loop
          if (!a_q[0] && !b_q[0]) begin
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            k_q <= k_q + KW'(1);
          end else begin
            state_q <= GCD;
          end
        end
        GCD: begin
          // a and b are nonzero here; subtraction always takes larger minus smaller
          if (a_q == b_q) begin
            g_q         <= a_q << k_q;
            div_start_q <= 1'b1;
            state_q     <= DIV;
          end else if (!a_q[0]) begin
            a_q <= a_q >> 1;
          end else if (!b_q[0]) begin
            b_q <= b_q >> 1;
          end else if (a_q > b_q) begin
            a_q <= a_q - b_q;
          end else begin
            b_q <= b_q - a_q;
          end
        end
        DIV: begin
          if (done_num && done_den) begin
            out_err_q   <= 1'b0;
            out_num_q   <= q_num;
            out_den_q   <= q_den;
`ifdef RAT_REDUCE_GCD_PORT_EN
            out_gcd_q   <= g_q;
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // g divides both terms, so a nonzero remainder means the GCD logic is broken
  a_exact_div: assert property (@(posedge clk) disable iff (!rst)
    (state_q == DIV && done_num && done_den) |-> (r_num == '0 && r_den == '0));

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign out_num   = out_num_q;
  assign out_den   = out_den_q;
`ifdef RAT_REDUCE_GCD_PORT_EN
  assign out_gcd   = out_gcd_q;
`endif

endmodule

// File: tb/tb_rat_reduce.sv
// Directed and randomised checks of rat_reduce against hand-computed values and a Euclid reference.
// Latency: checks exact 2-cycle zero/error latency and the general bound.
// Backpressure: holds out_ready low to check result stability.
module tb_rat_reduce;
  import rat_pkg::*;

  localparam int W = RAT_WIDTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_num = '0;
  logic [W-1:0] in_den = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_num, out_den;
  logic         out_err;
  logic         out_valid;
  logic         out_ready = 1'b1;
`ifdef RAT_REDUCE_GCD_PORT_EN
  logic [W-1:0] out_gcd;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int unsigned bound;

  rat_reduce #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_num    (in_num),
    .in_den    (in_den),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_num   (out_num),
    .out_den   (out_den),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RAT_REDUCE_GCD_PORT_EN
    ,.out_gcd  (out_gcd)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Present one pair; returns at the falling edge after the transfer edge
  task automatic send(input logic [W-1:0] n, input logic [W-1:0] d);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    in_num   = n;
    in_den   = d;
    in_valid = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    while (!out_valid && cyc < int'(bound)) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  // Check the held result, then let out_ready (assumed high) take it
  task automatic finish_case(input string tag, input logic [W-1:0] en, input logic [W-1:0] ed,
                             input logic ee, input logic [W-1:0] eg);
    wait_out();
    chk({tag, " valid"}, 64'(out_valid), 64'(1));
    chk({tag, " latency<=bound"}, 64'(cyc <= int'(bound)), 64'(1));
    chk({tag, " num"}, 64'(out_num), 64'(en));
    chk({tag, " den"}, 64'(out_den), 64'(ed));
    chk({tag, " err"}, 64'(out_err), 64'(ee));
`ifdef RAT_REDUCE_GCD_PORT_EN
    chk({tag, " gcd"}, 64'(out_gcd), 64'(eg));
`endif
    @(posedge clk);
    @(negedge clk);
    chk({tag, " valid cleared"}, 64'(out_valid), 64'(0));
    chk({tag, " in_ready back"}, 64'(in_ready), 64'(1));
  endtask

  task automatic run_case(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                          input logic [W-1:0] en, input logic [W-1:0] ed,
                          input logic ee, input logic [W-1:0] eg);
    send(n, d);
    chk({tag, " busy in_ready"}, 64'(in_ready), 64'(0));
    finish_case(tag, en, ed, ee, eg);
  endtask

  initial begin
    logic         stable;
    logic [W-1:0] rn, rd, rg;
    bound = rat_lat_bound(W);

    // Reset values
    #2 rst = 1'b0;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'(1));
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst out_err", 64'(out_err), 64'(0));
    chk("rst out_num", 64'(out_num), 64'(0));
    chk("rst out_den", 64'(out_den), 64'(0));
`ifdef RAT_REDUCE_GCD_PORT_EN
    chk("rst out_gcd", 64'(out_gcd), 64'(0));
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // General case with out_ready already high before the result exists
    out_ready = 1'b1;
    run_case("12/18", 32'd12, 32'd18, 32'd2, 32'd3, 1'b0, 32'd6);

    // Zero numerator and zero denominator: exactly two cycles
    run_case("0/7", 32'd0, 32'd7, 32'd0, 32'd1, 1'b0, 32'd7);
    chk("0/7 cycles", 64'(cyc), 64'(2));
    run_case("5/0", 32'd5, 32'd0, 32'd5, 32'd0, 1'b1, 32'd0);
    chk("5/0 cycles", 64'(cyc), 64'(2));

    // Full-scale and equal terms
    run_case("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 32'hFFFF_FFFF);
    run_case("1000/1000", 32'd1000, 32'd1000, 32'd1, 32'd1, 1'b0, 32'd1000);

    // 1024/768 with a competing pair offered while busy
    send(32'd1024, 32'd768);
    for (int i = 0; i < 5; i++) begin
      in_num   = 32'd7;
      in_den   = 32'd9;
      in_valid = 1'b1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("busy ignore in_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    finish_case("1024/768", 32'd4, 32'd3, 1'b0, 32'd256);

    // Backpressure: result held for 20 cycles, then accepted
    out_ready = 1'b0;
    send(32'd1000, 32'd250);
    wait_out();
    chk("bp valid", 64'(out_valid), 64'(1));
    chk("bp num", 64'(out_num), 64'(4));
    chk("bp den", 64'(out_den), 64'(1));
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || out_num !== 32'd4 || out_den !== 32'd1) stable = 1'b0;
    end
    chk("bp held stable", 64'(stable), 64'(1));
    chk("bp in_ready low", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp accepted", 64'(out_valid), 64'(0));
    chk("bp in_ready back", 64'(in_ready), 64'(1));

    // Reset while in the GCD loop, then a fresh pair
    send(32'd999, 32'd333);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("midrst in_ready", 64'(in_ready), 64'(1));
    chk("midrst out_valid", 64'(out_valid), 64'(0));
    chk("midrst out_err", 64'(out_err), 64'(0));
    chk("midrst out_num", 64'(out_num), 64'(0));
    chk("midrst out_den", 64'(out_den), 64'(0));
    repeat (3) @(negedge clk);
    chk("midrst still idle", 64'(out_valid), 64'(0));
    rst = 1'b1;
    run_case("6/4", 32'd6, 32'd4, 32'd3, 32'd2, 1'b0, 32'd2);

    // Random small pairs against a Euclid reference
    for (int i = 0; i < 1000; i++) begin
      rn = W'($urandom_range(999, 0));
      rd = W'($urandom_range(999, 1));
      rg = ref_gcd(rn, rd);
      run_case("rand", rn, rd, rn / rg, rd / rg, 1'b0, rg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
